// File: rtl/des_scheduler_if.sv
// Requester-side bus of des_scheduler: per-requester request handshake plus routed response.
// Requester i owns bits [64*i +: 64] of the packed text/key fields.
interface des_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [64*NUM_REQ-1:0] req_plain_text;
  logic [64*NUM_REQ-1:0] req_cipher_key;
  logic [NUM_REQ-1:0]    req_encrypt_decrypt;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [63:0]           resp_text;

  modport master (
    output req_valid, req_plain_text, req_cipher_key, req_encrypt_decrypt,
    input  req_ready, resp_valid, resp_text
  );

  modport slave (
    input  req_valid, req_plain_text, req_cipher_key, req_encrypt_decrypt,
    output req_ready, resp_valid, resp_text
  );
endinterface

// File: rtl/des_scheduler.sv
// des_scheduler: round-robin sequencer sharing one pipelined DES core; DES_SCHED_PRIO_EN gives requester 0 strict priority.
// Latency: grant -> des_valid_in 1 cycle; des_valid_out -> resp_valid 1 cycle.
// Backpressure: no grants when the in-order tag FIFO is full or while draining after flush.
module des_scheduler #(
  parameter int  NUM_REQ      = 4,
  parameter int  MAX_INFLIGHT = 16,
  parameter int  ID_W         = $clog2(NUM_REQ),
  localparam int PTR_W        = $clog2(MAX_INFLIGHT),
  localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  des_scheduler_if.slave   bus,
  output logic [63:0]      des_plain_text,
  output logic [63:0]      des_cipher_key,
  output logic             des_encrypt_decrypt,
  output logic             des_valid_in,
  input  logic [63:0]      des_cipher_text,
  input  logic             des_valid_out,
  output logic             busy,
  output logic [CNT_W-1:0] inflight_count
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    next_ptr;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    scan_id;
  logic               grant_found;
  logic               can_grant;
  logic               push;
  logic               pop;
  logic [NUM_REQ-1:0] rr_cand;
  logic [ID_W-1:0]    tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ID_W-1:0]    head_id;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    rr_cand = bus.req_valid;
`ifdef DES_SCHED_PRIO_EN
    rr_cand[0] = 1'b0;
`endif
    grant_found = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_id = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (rr_cand[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
`ifdef DES_SCHED_PRIO_EN
    if (bus.req_valid[0]) begin
      grant_found = 1'b1;
      grant_id    = '0;
    end
`endif
  end

  // Full check uses the pre-pop count, so a pop only frees a slot for the next cycle.
  assign can_grant = (state == ST_RUN) && (inflight_count < CNT_W'(MAX_INFLIGHT));
  assign push      = can_grant && grant_found;
  assign pop       = des_valid_out && (inflight_count != '0);
  assign head_id   = tag_mem[rd_ptr];
  assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  assign busy      = (inflight_count != '0) || (state == ST_DRAIN);

  always_comb begin
    bus.req_ready = '0;
    if (push) bus.req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_RUN;
      rr_ptr              <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      inflight_count      <= '0;
      des_plain_text      <= '0;
      des_cipher_key      <= '0;
      des_encrypt_decrypt <= 1'b0;
      des_valid_in        <= 1'b0;
      bus.resp_valid      <= '0;
      bus.resp_text       <= '0;
    end else begin
      case (state)
        ST_RUN:  if (flush) state <= ST_DRAIN;
        default: if ((inflight_count == '0) && !flush) state <= ST_RUN;
      endcase

      des_valid_in <= push;
      if (push) begin
        des_plain_text      <= bus.req_plain_text[64*grant_id +: 64];
        des_cipher_key      <= bus.req_cipher_key[64*grant_id +: 64];
        des_encrypt_decrypt <= bus.req_encrypt_decrypt[grant_id];
        wr_ptr              <= wr_ptr + PTR_W'(1);
`ifdef DES_SCHED_PRIO_EN
        if (grant_id != '0) rr_ptr <= next_ptr;
`else
        rr_ptr <= next_ptr;
`endif
      end

      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   inflight_count <= inflight_count + CNT_W'(1);
        2'b01:   inflight_count <= inflight_count - CNT_W'(1);
        default: ;
      endcase

      // Results arriving with nothing outstanding are dropped.
      bus.resp_valid <= '0;
      if (pop) begin
        bus.resp_valid[head_id] <= 1'b1;
        bus.resp_text           <= des_cipher_text;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_id;
  end

endmodule

// File: tb/tb_des_scheduler.sv
// Bench for des_scheduler: requester queues, a behavioural pipelined core stub and an in-order response scoreboard.
`timescale 1ns/1ps
module tb_des_scheduler;
  localparam int NR   = 4;
  localparam int MAXF = 16;
  localparam int LAT  = 3;
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;

  typedef struct packed { logic [63:0] pt; logic [63:0] key; logic enc; } req_t;
  typedef struct packed { logic [1:0] id; logic [63:0] txt; } exp_t;
  typedef struct packed { logic [63:0] txt; logic [31:0] due; } pipe_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        core_hold = 1'b0;
  logic [63:0] des_plain_text, des_cipher_key, des_cipher_text;
  logic        des_encrypt_decrypt, des_valid_in, des_valid_out, busy;
  logic [4:0]  inflight_count;

  des_scheduler_if #(.NUM_REQ(NR)) bus();

  des_scheduler #(.NUM_REQ(NR), .MAX_INFLIGHT(MAXF), .ID_W(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .bus                 (bus),
    .des_plain_text      (des_plain_text),
    .des_cipher_key      (des_cipher_key),
    .des_encrypt_decrypt (des_encrypt_decrypt),
    .des_valid_in        (des_valid_in),
    .des_cipher_text     (des_cipher_text),
    .des_valid_out       (des_valid_out),
    .busy                (busy),
    .inflight_count      (inflight_count)
  );

  req_t  rq [NR][$];
  exp_t  sb[$];
  pipe_t pipe[$];
  int    grant_log[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    resp_cnt = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Known DES vector pair, otherwise an arbitrary reversible-looking mix.
  function automatic logic [63:0] core_fn(input logic [63:0] p, input logic [63:0] k, input logic e);
    if (k == KEY && !e && p == PT) return CT;
    if (k == KEY && e && p == CT) return PT;
    return p ^ {k[31:0], k[63:32]} ^ {64{e}};
  endfunction

  function automatic req_t rnd_req();
    return req_t'{pt: {$urandom, $urandom}, key: {$urandom, $urandom}, enc: 1'($urandom_range(0, 1))};
  endfunction

  function automatic logic idle_now();
    logic r;
    r = (sb.size() == 0) && (pipe.size() == 0) && (inflight_count == 5'd0) && !des_valid_in;
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic wait_count(input int val, input int budget, input string tag);
    int n = 0;
    while (inflight_count != 5'(val) && n < budget) begin tick(); n++; end
    chk(tag, 64'(inflight_count), 64'(val));
  endtask

  task automatic wait_dvo(input int budget, input string tag);
    int n = 0;
    while (des_valid_out !== 1'b1 && n < budget) begin tick(); n++; end
    chk(tag, 64'(des_valid_out), 64'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!idle_now() && n < budget) begin tick(); n++; end
    chk(tag, 64'(idle_now()), 64'd1);
  endtask

  // Requester side: present queue heads, record handshakes, score responses.
  initial begin
    logic [NR-1:0]    v, en;
    logic [64*NR-1:0] ptv, keyv;
    logic [3:0]       oh;
    exp_t             e;
    bus.req_valid = '0;
    bus.req_plain_text = '0;
    bus.req_cipher_key = '0;
    bus.req_encrypt_decrypt = '0;
    forever begin
      @(negedge clk);
      #2;
      v = '0; en = '0; ptv = '0; keyv = '0;
      for (int i = 0; i < NR; i++) begin
        if (rq[i].size() != 0) begin
          v[i] = 1'b1;
          ptv[64*i +: 64]  = rq[i][0].pt;
          keyv[64*i +: 64] = rq[i][0].key;
          en[i] = rq[i][0].enc;
        end
      end
      bus.req_valid = v;
      bus.req_plain_text = ptv;
      bus.req_cipher_key = keyv;
      bus.req_encrypt_decrypt = en;
      #1;
      if (bus.resp_valid != '0) resp_cnt++;
      if (sb.size() == 0) begin
        chk("resp_spurious", 64'(bus.resp_valid), 64'd0);
      end else if (bus.resp_valid != '0) begin
        e = sb.pop_front();
        oh = 4'b0001 << e.id;
        chk("resp_owner", 64'(bus.resp_valid), 64'(oh));
        chk("resp_text", bus.resp_text, e.txt);
      end
      chk("inflight_max", 64'(inflight_count <= 5'(MAXF)), 64'd1);
      for (int i = 0; i < NR; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb.push_back(exp_t'{id: 2'(i), txt: core_fn(rq[i][0].pt, rq[i][0].key, rq[i][0].enc)});
          grant_log.push_back(i);
          void'(rq[i].pop_front());
        end
      end
    end
  end

  // Core stub: fixed latency, results can be held back with core_hold; survives scheduler reset.
  initial begin
    logic [31:0] cyc;
    cyc = 0;
    des_valid_out = 1'b0;
    des_cipher_text = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (des_valid_in === 1'b1)
        pipe.push_back(pipe_t'{txt: core_fn(des_plain_text, des_cipher_key, des_encrypt_decrypt), due: cyc + LAT});
      if (!core_hold && pipe.size() != 0 && pipe[0].due <= cyc) begin
        des_valid_out = 1'b1;
        des_cipher_text = pipe[0].txt;
        void'(pipe.pop_front());
      end else begin
        des_valid_out = 1'b0;
        des_cipher_text = '0;
      end
    end
  end

  initial begin
    int exp2 [8];
    int exp6 [3];
    int base;
    int n;
`ifdef DES_SCHED_PRIO_EN
    exp2 = '{0, 0, 1, 2, 3, 1, 2, 3};
    exp6 = '{0, 0, 0};
`else
    exp2 = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp6 = '{0, 1, 0};
`endif
    rst = 1'b1;
    tick(); tick();
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp", 64'(bus.resp_valid), 64'd0);
    chk("rst_vin", 64'(des_valid_in), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(inflight_count), 64'd0);
    rst = 1'b0;
    tick();

    // Single encrypt then decrypt on requester 2.
    rq[2].push_back(req_t'{pt: PT, key: KEY, enc: 1'b0});
    tick();
    chk("t1_grant", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    chk("t1_vin", 64'(des_valid_in), 64'd1);
    chk("t1_pt", des_plain_text, PT);
    chk("t1_key", des_cipher_key, KEY);
    chk("t1_enc", 64'(des_encrypt_decrypt), 64'd0);
    chk("t1_count", 64'(inflight_count), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_dvo(20, "t1_dvo");
    tick();
    chk("t1_resp_valid", 64'(bus.resp_valid), 64'(4'b0100));
    chk("t1_resp_text", bus.resp_text, CT);
    wait_idle(50, "t1_idle");
    rq[2].push_back(req_t'{pt: CT, key: KEY, enc: 1'b1});
    tick(); tick();
    chk("t1_dec_flag", 64'(des_encrypt_decrypt), 64'd1);
    wait_dvo(20, "t1_dec_dvo");
    tick();
    chk("t1_dec_text", bus.resp_text, PT);
    wait_idle(50, "t1_dec_idle");

    // Round-robin over all four from a fresh pointer.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) rq[i].push_back(rnd_req());
    wait_idle(200, "t2_idle");
    chk("t2_ngrants", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk($sformatf("t2_order%0d", i), 64'(grant_log[i]), 64'(exp2[i]));
    chk("t2_count", 64'(inflight_count), 64'd0);

    // Fill to MAX_INFLIGHT and release.
    core_hold = 1'b1;
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < NR; i++) rq[i].push_back(rnd_req());
    wait_count(MAXF, 80, "t3_full");
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("t3_pending", 64'(bus.req_valid != '0), 64'd1);
      chk("t3_ready_full", 64'(bus.req_ready), 64'd0);
      chk("t3_count_full", 64'(inflight_count), 64'(MAXF));
    end
    core_hold = 1'b0;
    wait_dvo(20, "t3_dvo");
    chk("t3_count_prepop", 64'(inflight_count), 64'(MAXF));
    chk("t3_ready_prepop", 64'(bus.req_ready), 64'd0);
    tick();
    chk("t3_count_after", 64'(inflight_count), 64'(MAXF - 1));
    chk("t3_grant_resume", 64'(bus.req_ready != '0), 64'd1);
    wait_idle(300, "t3_idle");

    // Flush with five in flight.
    core_hold = 1'b1;
    for (int i = 0; i < 5; i++) rq[i % NR].push_back(rnd_req());
    wait_count(5, 40, "t4_five");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    base = resp_cnt;
    rq[1].push_back(rnd_req());
    tick();
    chk("t4_valid_held", 64'(bus.req_valid[1]), 64'd1);
    chk("t4_ready_drain", 64'(bus.req_ready), 64'd0);
    chk("t4_busy_drain", 64'(busy), 64'd1);
    core_hold = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      chk("t4_nogrant", 64'(bus.req_ready), 64'd0);
    end while (inflight_count != 5'd0 && n < 40);
    chk("t4_drained", 64'(inflight_count), 64'd0);
    chk("t4_busy_last", 64'(busy), 64'd1);
    chk("t4_resp_cnt", 64'(resp_cnt - base), 64'd5);
    tick();
    chk("t4_busy_fall", 64'(busy), 64'd0);
    chk("t4_run_grant", 64'(bus.req_ready), 64'(4'b0010));
    wait_idle(50, "t4_idle");

    // Reset with three in flight; late core results must vanish.
    core_hold = 1'b1;
    for (int i = 0; i < 3; i++) rq[i].push_back(rnd_req());
    wait_count(3, 40, "t5_three");
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("t5_ready", 64'(bus.req_ready), 64'd0);
    chk("t5_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("t5_resp_text", bus.resp_text, 64'd0);
    chk("t5_vin", 64'(des_valid_in), 64'd0);
    chk("t5_pt", des_plain_text, 64'd0);
    chk("t5_key", des_cipher_key, 64'd0);
    chk("t5_enc", 64'(des_encrypt_decrypt), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_count", 64'(inflight_count), 64'd0);
    base = resp_cnt;
    core_hold = 1'b0;
    repeat (12) tick();
    chk("t5_no_late_resp", 64'(resp_cnt - base), 64'd0);
    chk("t5_count_after", 64'(inflight_count), 64'd0);

    // Requesters 0 and 1 competing.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    grant_log.delete();
    for (int r = 0; r < 3; r++) begin
      rq[0].push_back(rnd_req());
      rq[1].push_back(rnd_req());
    end
    wait_idle(100, "t6_idle");
    chk("t6_ngrants", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 3 && i < grant_log.size(); i++)
      chk($sformatf("t6_order%0d", i), 64'(grant_log[i]), 64'(exp6[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
